// File: rtl/axis_ipsa_bridge_if.sv
// Signal bundle between the AXI-Stream side, the IPSA pipeline and the bridge.
// The slave modport is the bridge's view; master is the view of its surroundings.
interface axis_ipsa_bridge_if #(
    parameter int AXIS_W = 512,
    parameter int RATIO  = 2
);
    localparam int IPSA_W = AXIS_W * RATIO;

    // Valid/ready: a beat transfers on a rising edge where tvalid && tready. Once tvalid
    // is raised, the source holds it and its payload until that transfer. IPSA strobes
    // (ipsa_io_en_*) have no ready and transfer in every cycle where the strobe is high.
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [AXIS_W-1:0]     s_axis_tdata;
    logic [AXIS_W/8-1:0]   s_axis_tkeep;

    logic                  ipsa_io_en_in;
    logic [IPSA_W-1:0]     ipsa_io_data_in;
    logic [IPSA_W/8-1:0]   ipsa_io_keep_in;
    logic                  ipsa_io_last_in;

    logic                  ipsa_io_en_out;
    logic [IPSA_W-1:0]     ipsa_io_data_out;
    logic [IPSA_W/8-1:0]   ipsa_io_keep_out;
    logic                  ipsa_io_last_out;

    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [AXIS_W-1:0]     m_axis_tdata;
    logic [AXIS_W/8-1:0]   m_axis_tkeep;

    modport master (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        input  s_axis_tready,
        input  ipsa_io_en_in, ipsa_io_data_in, ipsa_io_keep_in, ipsa_io_last_in,
        output ipsa_io_en_out, ipsa_io_data_out, ipsa_io_keep_out, ipsa_io_last_out,
        input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep,
        output s_axis_tready,
        output ipsa_io_en_in, ipsa_io_data_in, ipsa_io_keep_in, ipsa_io_last_in,
        input  ipsa_io_en_out, ipsa_io_data_out, ipsa_io_keep_out, ipsa_io_last_out,
        output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        input  m_axis_tready
    );
endinterface

// File: rtl/axis_ipsa_bridge.sv
// AXI-Stream <-> IPSA bridge: packs RATIO narrow beats into one wide IPSA word on ingress,
// buffers IPSA output words in a FIFO and unpacks them to AXIS beats on egress.
module axis_ipsa_bridge #(
    parameter int AXIS_W     = 512,
    parameter int RATIO      = 2,
    parameter int DEPTH      = 16,
    parameter int PIPE_SLACK = 4
) (
    input  logic                clock,
    input  logic                reset,
    axis_ipsa_bridge_if.slave   bus,
    input  logic                stat_clear,
    output logic [31:0]         drop_count,
    output logic                overflow
);
    localparam int IPSA_W = AXIS_W * RATIO;
    localparam int KW     = AXIS_W / 8;
    localparam int IKW    = IPSA_W / 8;
    localparam int EW     = 1 + IKW + IPSA_W;
    localparam int IW     = $clog2(RATIO);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam logic [IW-1:0] LAST_LANE = IW'(RATIO - 1);

    // ---------------- ingress packer ----------------
    logic [IW-1:0]     in_idx;
    logic [IPSA_W-1:0] acc_data, acc_data_nxt;
    logic [IKW-1:0]    acc_keep, acc_keep_nxt;
    logic              in_fire, in_done;

    assign in_fire = bus.s_axis_tvalid && bus.s_axis_tready;
    assign in_done = in_fire && (bus.s_axis_tlast || in_idx == LAST_LANE);

    // The accumulator is cleared on every completion, so lanes above the final beat read zero.
    always_comb begin
        acc_data_nxt = acc_data;
        acc_keep_nxt = acc_keep;
        acc_data_nxt[int'(in_idx)*AXIS_W +: AXIS_W] = bus.s_axis_tdata;
        acc_keep_nxt[int'(in_idx)*KW +: KW]         = bus.s_axis_tkeep;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_idx              <= '0;
            acc_data            <= '0;
            acc_keep            <= '0;
            bus.ipsa_io_en_in   <= 1'b0;
            bus.ipsa_io_data_in <= '0;
            bus.ipsa_io_keep_in <= '0;
            bus.ipsa_io_last_in <= 1'b0;
        end else begin
            bus.ipsa_io_en_in <= in_done;
            if (in_done) begin
                in_idx              <= '0;
                acc_data            <= '0;
                acc_keep            <= '0;
                bus.ipsa_io_data_in <= acc_data_nxt;
                bus.ipsa_io_keep_in <= acc_keep_nxt;
                bus.ipsa_io_last_in <= bus.s_axis_tlast;
            end else if (in_fire) begin
                in_idx   <= in_idx + 1'b1;
                acc_data <= acc_data_nxt;
                acc_keep <= acc_keep_nxt;
            end
        end
    end

    // ---------------- egress FIFO ----------------
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push_req, full, push, pop, drop;

    assign push_req = bus.ipsa_io_en_out && (bus.ipsa_io_keep_out != '0);
    assign full     = (count == CW'(DEPTH));
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Ingress is throttled so that words already inside IPSA still find room.
    assign bus.s_axis_tready = (CW'(DEPTH) - count) > CW'(PIPE_SLACK);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {bus.ipsa_io_last_out, bus.ipsa_io_keep_out, bus.ipsa_io_data_out};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // ---------------- egress unpacker ----------------
    logic [EW-1:0]     head;
    logic [IPSA_W-1:0] head_data;
    logic [IKW-1:0]    head_keep;
    logic              head_last;
    logic [IW-1:0]     out_idx;
    logic              out_valid, out_fire, next_lane_empty, lane_last, lane_end;
    logic [AXIS_W-1:0] lane_data;
    logic [KW-1:0]     lane_keep;

    assign head      = mem[rd_ptr];
    assign head_data = head[IPSA_W-1:0];
    assign head_keep = head[IPSA_W +: IKW];
    assign head_last = head[EW-1];
    assign out_valid = (count != '0);

    always_comb begin
        lane_data       = head_data[int'(out_idx)*AXIS_W +: AXIS_W];
        lane_keep       = head_keep[int'(out_idx)*KW +: KW];
        next_lane_empty = 1'b1;
        for (int k = 1; k < RATIO; k++) begin
            if (k == int'(out_idx) + 1)
                next_lane_empty = (head_keep[k*KW +: KW] == '0);
        end
    end

    assign lane_last = head_last && (out_idx == LAST_LANE || next_lane_empty);
    assign lane_end  = lane_last || (out_idx == LAST_LANE);
    assign out_fire  = out_valid && bus.m_axis_tready;
    assign pop       = out_fire && lane_end;

    // Payload is forced to zero while idle so stale FIFO contents never show on the bus.
    assign bus.m_axis_tvalid = out_valid;
    assign bus.m_axis_tdata  = out_valid ? lane_data : '0;
    assign bus.m_axis_tkeep  = out_valid ? lane_keep : '0;
    assign bus.m_axis_tlast  = out_valid && lane_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         out_idx <= '0;
        else if (pop)      out_idx <= '0;
        else if (out_fire) out_idx <= out_idx + 1'b1;
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (stat_clear) begin
            drop_count <= drop ? 32'd1 : 32'd0;
            overflow   <= drop;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
        end
    end
endmodule

// File: doc/axis_ipsa_bridge.md
# axis_ipsa_bridge

Parametrised AXI-Stream ⇄ IPSA pipeline bridge that replaces the fixed 512→1024 converter pair and its ingress/egress adapters with a single block. On ingress it packs RATIO narrow AXIS beats into one wide IPSA word with keep/last sideband. On egress it buffers IPSA output words in a DEPTH-entry FIFO and unpacks them back to AXIS beats under full backpressure. It also throttles ingress on egress occupancy and counts words dropped on overflow, because the IPSA pipeline itself has no backpressure.

## Interface
Parameters:
- AXIS_W, 512, AXIS data width in bits; multiple of 8.
- RATIO, 2, AXIS beats per IPSA word; IPSA_W = AXIS_W*RATIO; RATIO ≥ 2.
- DEPTH, 16, egress FIFO entries; power of two, ≥ 4.
- PIPE_SLACK, 4, egress free entries reserved for words in flight in IPSA; 0 < PIPE_SLACK < DEPTH.

Ports:
- clock  in  1  sole clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1 each  ingress AXIS handshake and end-of-packet.
- s_axis_tdata  in  AXIS_W  ingress data.
- s_axis_tkeep  in  AXIS_W/8  ingress byte enables.
- ipsa_io_en_in  out  1  one-cycle strobe: IPSA input word valid.
- ipsa_io_data_in  out  IPSA_W  packed word.
- ipsa_io_keep_in  out  IPSA_W/8  packed byte enables.
- ipsa_io_last_in  out  1  word ends a packet.
- ipsa_io_en_out  in  1  IPSA output word strobe.
- ipsa_io_data_out / ipsa_io_keep_out / ipsa_io_last_out  in  IPSA_W / IPSA_W/8 / 1  IPSA output word.
- m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each  egress AXIS.
- m_axis_tdata  out  AXIS_W;  m_axis_tkeep  out  AXIS_W/8.
- stat_clear  in  1  synchronous clear of statistics.
- drop_count  out  32  saturating count of dropped egress words.
- overflow  out  1  sticky: at least one drop since reset/clear.

## Operation
Ingress packer:
- Beat index i in 0..RATIO-1. An accepted beat is written to lane i, i.e. bits [i*AXIS_W +: AXIS_W] of data and [i*AXIS_W/8 +: AXIS_W/8] of keep.
- The word completes when the accepted beat has i==RATIO-1 or tlast=1. On completion, lanes above i are forced to data 0 and keep 0, last=tlast, and i returns to 0.
- s_axis_tready = (egress free entries > PIPE_SLACK). It is computed combinationally from registered FIFO count only, never from s_axis_tvalid.

Egress FIFO:
- Entry = {last, keep, data}. A push occurs on ipsa_io_en_out.
- A word with keep all zero is discarded silently and not counted.
- A push while full with no pop in the same cycle drops the word: drop_count+1, saturating at 0xFFFF_FFFF, and overflow=1.
- A push while full with a pop in the same cycle is accepted.

Egress unpacker:
- Head word, beat index j. Outputs: m_axis_tdata = lane j, m_axis_tkeep = keep lane j.
- m_axis_tlast = last && (j==RATIO-1 || keep lane j+1 == 0).
- On handshake: if tlast or j==RATIO-1, pop and set j=0; else j+1. Trailing empty lanes of a last word are never emitted.
- Non-last words emit all RATIO beats.
- Once asserted, m_axis_tvalid and its payload hold until handshake.

Statistics:
- stat_clear zeroes drop_count and overflow.
- stat_clear coincident with a drop yields drop_count=1, overflow=1.

## Timing
- Reset values: ipsa_io_en_in=0, ipsa_io_data_in/keep_in/last_in=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, drop_count=0, overflow=0. s_axis_tready=1 (FIFO empty, DEPTH > PIPE_SLACK).
- Ingress latency: ipsa_io_en_in asserts exactly 1 cycle after the completing beat is accepted, high for 1 cycle. Back-to-back words on consecutive completions are allowed.
- Egress latency: a word pushed in cycle t can be presented as m_axis_tvalid in cycle t+1 at the earliest. Sustained throughput is 1 AXIS beat/cycle.
- s_axis_tready updates the cycle after the FIFO count changes.
- Reset mid-packet: partial ingress word and all FIFO contents are discarded, and i=j=0. No strobe is emitted for the partial word.
- Reset deasserts asynchronously. Outputs must be stable by the first clock edge after deassertion.

## Test plan
- AXIS_W=512, RATIO=2: 2 full beats A,B (tkeep all 1, tlast on B) -> one ipsa_io_en_in pulse 1 cycle after B, data={B,A}, keep all 1, last=1.
- 1 beat C with tkeep=0x0000_0000_0000_00FF and tlast=1 -> word {0,C}, keep lanes = {0, 0xFF}, last=1. Loopback to egress -> single AXIS beat C, tkeep 0xFF, tlast=1.
- Egress word with last=0, keep all 1, while m_axis_tready toggles 1,0,1 -> 2 beats lane0 then lane1, payload stable while stalled, tlast=0 on both.
- m_axis_tready=0 and 16 pushes -> s_axis_tready falls once free ≤ 4; 17th push -> drop_count=1, overflow=1. Push coincident with pop when full -> no drop.
- Drop_count preset near 0xFFFF_FFFF via repeated overflow -> saturates. stat_clear alone -> 0/0; stat_clear with drop -> 1/1.
- Reset asserted after the first beat of a 2-beat packet -> no ipsa_io_en_in. The next clean packet packs starting at lane 0.
